uart_terminal_tx: RTL and testbench

//  6809-to-terminal UART transmitter: buffers bytes written by the 6809 bus

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_fifo.sv | 85 ++++++++
 rtl/uart_terminal_tx.sv | 188 ++++++++++++++++++
 tb/tb_uart_terminal_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the terminal UART transmitter:
//   - uart_state_t : transmitter FSM state encoding
//   - DATA_BITS    : data bits per frame (8N1)
//   - calc_div     : clocks per bit, CLK_HZ/BAUD rounded to nearest
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS = 8;

    // Round to nearest by adding half the divisor before the integer divide.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + (baud / 2)) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous FIFO buffering bytes between the bus write strobe and the
// serialiser. Head-of-queue data is presented combinationally on 'head'.
//
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   push        : write request (accepted when not full, or full with pop)
//   push_data   : byte to store
//   pop         : remove head entry (ignored when empty)
//   head        : current head-of-queue byte
//   full, empty : registered occupancy flags
//   level       : registered occupancy count, 0..DEPTH
//   overflow    : combinational, high when a push is being dropped this clk
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      level_next;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full FIFO still fits when the head leaves in the same clk.
    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        overflow = push && !push_ok;
        level_next = level;
        case ({push_ok, pop_ok})
            2'b10:   level_next = level + 1'b1;
            2'b01:   level_next = level - 1'b1;
            default: level_next = level;
        endcase
    end

    // Storage has no reset; only the pointers and flags define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Pointers carry one extra MSB so a wrapped write pointer is
    // distinguishable from an equal read pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level_next;
            full  <= (level_next == (AW+1)'(DEPTH));
            empty <= (level_next == '0);
        end
    end

    assign head = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_terminal_tx.sv
// ---------------------------------------------------------------------------
// uart_terminal_tx
// 6809-to-terminal UART transmitter. Buffers bytes written by the bus decode
// logic and sends them 8N1, LSB first, on o_UART_RX (FT2232 RX pin).
//
// Build option: define UART_CTS_FLOW_EN to honour FT2232 CTS# (active-low)
// through a 2-FF synchroniser. Left undefined, transmission never waits on
// CTS# and i_UART_CTS is ignored.
//
// Ports
//   clk, rst    : system clock, asynchronous active-high reset
//   i_wr_en     : 1-clk write strobe, i_wr_data valid with it
//   i_wr_data   : byte to transmit
//   i_clr_ovr   : 1-clk strobe clearing o_overrun
//   i_UART_CTS  : FT2232 CTS#, active-low, asynchronous
//   o_UART_RX   : serial line, idles high
//   o_full      : FIFO holds FIFO_DEPTH entries
//   o_empty     : FIFO holds no entries
//   o_busy      : frame in progress
//   o_overrun   : sticky, a write was dropped on a full FIFO
//   o_level     : FIFO occupancy
// ---------------------------------------------------------------------------
module uart_terminal_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 53_200_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_wr_en,
    input  logic [7:0]                      i_wr_data,
    input  logic                            i_clr_ovr,
    input  logic                            i_UART_CTS,
    output logic                            o_UART_RX,
    output logic                            o_full,
    output logic                            o_empty,
    output logic                            o_busy,
    output logic                            o_overrun,
    output logic [$clog2(FIFO_DEPTH):0]     o_level
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    uart_state_t         state;
    uart_state_t         state_next;
    logic [CW-1:0]       baud_cnt;
    logic [2:0]          bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                tx_line;
    logic                baud_done;
    logic                pop;
    logic                cts_ok;
    logic [7:0]          fifo_head;
    logic                fifo_overflow;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (i_wr_en),
        .push_data (i_wr_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (o_full),
        .empty     (o_empty),
        .level     (o_level),
        .overflow  (fifo_overflow)
    );

`ifdef UART_CTS_FLOW_EN
    logic cts_meta;
    logic cts_sync;

    // Two-flop synchroniser for the asynchronous CTS# pin. Resets to the
    // "not clear" level so nothing is sent until the pin is seen low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cts_meta <= 1'b1;
            cts_sync <= 1'b1;
        end else begin
            cts_meta <= i_UART_CTS;
            cts_sync <= cts_meta;
        end
    end

    assign cts_ok = ~cts_sync;
`else
    logic unused_cts;

    assign unused_cts = i_UART_CTS;
    assign cts_ok     = 1'b1;
`endif

    assign baud_done = (baud_cnt == CW'(DIV - 1));

    // Next-state and pop decision. CTS is only consulted when a new frame
    // is about to begin, so a frame in flight always completes.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!o_empty && cts_ok) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_done && (bit_cnt == 3'(DATA_BITS - 1))) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    if (!o_empty && cts_ok) begin
                        pop        = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath registers. The baud counter is held at zero in IDLE and
    // restarts after every bit period, so each state entry starts a fresh
    // DIV-clock interval. The line is registered from the current state,
    // which places the start bit one clock after the pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx_line   <= 1'b1;
            o_overrun <= 1'b0;
        end else begin
            state <= state_next;

            if ((state == ST_IDLE) || baud_done) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            if (state != ST_DATA) begin
                bit_cnt <= '0;
            end else if (baud_done) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (pop) begin
                shift_reg <= fifo_head;
            end else if ((state == ST_DATA) && baud_done) begin
                shift_reg <= {1'b0, shift_reg[DATA_BITS-1:1]};
            end

            case (state)
                ST_START: tx_line <= 1'b0;
                ST_DATA:  tx_line <= shift_reg[0];
                default:  tx_line <= 1'b1;
            endcase

            // A dropped write outranks a clear in the same clock.
            if (fifo_overflow) begin
                o_overrun <= 1'b1;
            end else if (i_clr_ovr) begin
                o_overrun <= 1'b0;
            end
        end
    end

    assign o_UART_RX = tx_line;
    assign o_busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_terminal_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_terminal_tx
// Directed bench for uart_terminal_tx. Runs at CLK_HZ=1_150_000, BAUD=100_000
// so a bit is (1_150_000 + 50_000) / 100_000 = 12 clocks and a frame 120,
// keeping the 16/17-frame burst short while exercising the rounding divider.
// CTS-dependent sequences follow the UART_CTS_FLOW_EN build option.
// ---------------------------------------------------------------------------
module tb_uart_terminal_tx;

    localparam int DIV_EXP = 12;
    localparam int LW      = 5;

`ifdef UART_CTS_FLOW_EN
    localparam logic CTS_IDLE = 1'b0;
`else
    localparam logic CTS_IDLE = 1'b1;
`endif

    logic          clk;
    logic          rst;
    logic          i_wr_en;
    logic [7:0]    i_wr_data;
    logic          i_clr_ovr;
    logic          i_UART_CTS;
    logic          o_UART_RX;
    logic          o_full;
    logic          o_empty;
    logic          o_busy;
    logic          o_overrun;
    logic [LW-1:0] o_level;

    int checks   = 0;
    int failures = 0;

    uart_terminal_tx #(
        .CLK_HZ     (1_150_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (i_wr_en),
        .i_wr_data  (i_wr_data),
        .i_clr_ovr  (i_clr_ovr),
        .i_UART_CTS (i_UART_CTS),
        .o_UART_RX  (o_UART_RX),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_busy     (o_busy),
        .o_overrun  (o_overrun),
        .o_level    (o_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one clock's worth of bus strobes; they are sampled at the next edge.
    task automatic applyStimulus(input logic wr, input logic [7:0] data, input logic clr);
        i_wr_en   = wr;
        i_wr_data = data;
        i_clr_ovr = clr;
        tick();
        i_wr_en   = 1'b0;
        i_clr_ovr = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called just after the edge where the start bit appears; checks the
    // first and last clock of every bit and returns one frame later.
    task automatic checkFrame(input logic [7:0] data, input int cts_rise_bit, input string tag);
        logic [9:0] bits;
        bits = {1'b1, data, 1'b0};
        for (int b = 0; b < 10; b++) begin
            if (b == cts_rise_bit) i_UART_CTS = 1'b1;
            checkOutput($sformatf("%s_bit%0d_first", tag, b), 32'(o_UART_RX), 32'(bits[b]));
            if (b == 9) checkOutput($sformatf("%s_busy_stop", tag), 32'(o_busy), 32'd1);
            repeat (DIV_EXP - 1) tick();
            checkOutput($sformatf("%s_bit%0d_last", tag, b), 32'(o_UART_RX), 32'(bits[b]));
            tick();
        end
    endtask

    initial begin
        rst        = 1'b1;
        i_wr_en    = 1'b0;
        i_wr_data  = 8'h00;
        i_clr_ovr  = 1'b0;
        i_UART_CTS = CTS_IDLE;

        // Reset state
        tick();
        tick();
        checkOutput("rst_line",    32'(o_UART_RX), 32'd1);
        checkOutput("rst_full",    32'(o_full),    32'd0);
        checkOutput("rst_empty",   32'(o_empty),   32'd1);
        checkOutput("rst_busy",    32'(o_busy),    32'd0);
        checkOutput("rst_overrun", 32'(o_overrun), 32'd0);
        checkOutput("rst_level",   32'(o_level),   32'd0);
        rst = 1'b0;
        repeat (3) tick();

        // Test 1: single byte 0x55, start bit two clocks after the write
        $display("[TB] test 1: single byte 0x55");
        applyStimulus(1'b1, 8'h55, 1'b0);
        checkOutput("t1_empty_n1", 32'(o_empty),   32'd0);
        checkOutput("t1_level_n1", 32'(o_level),   32'd1);
        checkOutput("t1_busy_n1",  32'(o_busy),    32'd0);
        checkOutput("t1_line_n1",  32'(o_UART_RX), 32'd1);
        tick();
        checkOutput("t1_busy_n2",  32'(o_busy),    32'd1);
        checkOutput("t1_empty_n2", 32'(o_empty),   32'd1);
        checkOutput("t1_level_n2", 32'(o_level),   32'd0);
        checkOutput("t1_line_n2",  32'(o_UART_RX), 32'd1);
        tick();
        checkFrame(8'h55, -1, "t1");
        checkOutput("t1_busy_end", 32'(o_busy),    32'd0);
        checkOutput("t1_line_end", 32'(o_UART_RX), 32'd1);

        // Test 2: three back-to-back bytes, contiguous frames
        $display("[TB] test 2: back-to-back 0x41 0x42 0x43");
        applyStimulus(1'b1, 8'h41, 1'b0);
        applyStimulus(1'b1, 8'h42, 1'b0);
        applyStimulus(1'b1, 8'h43, 1'b0);
        checkOutput("t2_level_3wr", 32'(o_level), 32'd2);
        checkFrame(8'h41, -1, "t2a");
        checkOutput("t2_level_a", 32'(o_level), 32'd1);
        checkOutput("t2_empty_a", 32'(o_empty), 32'd0);
        checkFrame(8'h42, -1, "t2b");
        checkOutput("t2_empty_b", 32'(o_empty), 32'd1);
        checkFrame(8'h43, -1, "t2c");
        checkOutput("t2_busy_end", 32'(o_busy), 32'd0);

`ifdef UART_CTS_FLOW_EN
        // Test 3: CTS# held off, 17 writes, 17th dropped, then release
        $display("[TB] test 3: fill under CTS# high");
        i_UART_CTS = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, 8'h10 + 8'(i), 1'b0);
        checkOutput("t3_full",    32'(o_full),    32'd1);
        checkOutput("t3_level",   32'(o_level),   32'd16);
        checkOutput("t3_overrun", 32'(o_overrun), 32'd1);
        checkOutput("t3_line",    32'(o_UART_RX), 32'd1);
        checkOutput("t3_busy",    32'(o_busy),    32'd0);
        applyStimulus(1'b1, 8'hDD, 1'b1);
        checkOutput("t3_set_wins", 32'(o_overrun), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t3_clr",      32'(o_overrun), 32'd0);
        repeat (20) tick();
        checkOutput("t3_line_hold", 32'(o_UART_RX), 32'd1);
        checkOutput("t3_busy_hold", 32'(o_busy),    32'd0);
        i_UART_CTS = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 16; i++) checkFrame(8'h10 + 8'(i), -1, $sformatf("t3f%0d", i));
        checkOutput("t3_empty_end", 32'(o_empty), 32'd1);
        checkOutput("t3_busy_end",  32'(o_busy),  32'd0);

        // Test 4: CTS# rises mid-frame, frame completes, next byte waits
        $display("[TB] test 4: CTS# rises mid-DATA");
        applyStimulus(1'b1, 8'hA5, 1'b0);
        applyStimulus(1'b1, 8'h5A, 1'b0);
        tick();
        checkFrame(8'hA5, 4, "t4a");
        checkOutput("t4_busy_wait",  32'(o_busy),    32'd0);
        checkOutput("t4_level_wait", 32'(o_level),   32'd1);
        repeat (20) tick();
        checkOutput("t4_line_wait",  32'(o_UART_RX), 32'd1);
        checkOutput("t4_busy_wait2", 32'(o_busy),    32'd0);
        i_UART_CTS = 1'b0;
        repeat (4) tick();
        checkFrame(8'h5A, -1, "t4b");
`else
        // Test 3: burst of 18 writes while the first frame is sent; one
        // byte is in flight, 16 buffered, the 18th dropped. A write landing
        // on the clock the next byte is popped is accepted while full.
        $display("[TB] test 3: burst overrun and full+pop write");
        for (int i = 0; i < 18; i++) applyStimulus(1'b1, 8'h10 + 8'(i), 1'b0);
        checkOutput("t3_full",    32'(o_full),    32'd1);
        checkOutput("t3_level",   32'(o_level),   32'd16);
        checkOutput("t3_overrun", 32'(o_overrun), 32'd1);
        checkOutput("t3_busy",    32'(o_busy),    32'd1);
        applyStimulus(1'b1, 8'hDD, 1'b1);
        checkOutput("t3_set_wins", 32'(o_overrun), 32'd1);
        checkOutput("t3_level2",   32'(o_level),   32'd16);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t3_clr",      32'(o_overrun), 32'd0);
        repeat (101) tick();
        applyStimulus(1'b1, 8'hEE, 1'b0);
        checkOutput("t3_popwr_level",   32'(o_level),   32'd16);
        checkOutput("t3_popwr_full",    32'(o_full),    32'd1);
        checkOutput("t3_popwr_overrun", 32'(o_overrun), 32'd0);
        tick();
        for (int i = 1; i < 17; i++) checkFrame(8'h10 + 8'(i), -1, $sformatf("t3f%0d", i));
        checkFrame(8'hEE, -1, "t3fEE");
        checkOutput("t3_empty_end", 32'(o_empty), 32'd1);
        checkOutput("t3_level_end", 32'(o_level), 32'd0);
        checkOutput("t3_busy_end",  32'(o_busy),  32'd0);
`endif

        // Test 5: asynchronous reset during data bit 4
        $display("[TB] test 5: reset mid-frame");
        applyStimulus(1'b1, 8'h2C, 1'b0);
        applyStimulus(1'b1, 8'h99, 1'b0);
        tick();
        repeat (65) tick();
        checkOutput("t5_line_pre",  32'(o_UART_RX), 32'd0);
        checkOutput("t5_level_pre", 32'(o_level),   32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t5_line_rst",  32'(o_UART_RX), 32'd1);
        checkOutput("t5_level_rst", 32'(o_level),   32'd0);
        checkOutput("t5_busy_rst",  32'(o_busy),    32'd0);
        checkOutput("t5_empty_rst", 32'(o_empty),   32'd1);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        applyStimulus(1'b1, 8'h0F, 1'b0);
        tick();
        tick();
        checkFrame(8'h0F, -1, "t5");

`ifndef UART_CTS_FLOW_EN
        // Test 6: CTS# held high has no effect without flow control
        $display("[TB] test 6: CTS# ignored, byte 0x00");
        i_UART_CTS = 1'b1;
        applyStimulus(1'b1, 8'h00, 1'b0);
        tick();
        tick();
        checkFrame(8'h00, -1, "t6");
        checkOutput("t6_busy_end", 32'(o_busy), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
